// File: rtl/fpm_pkg.sv
// fpm_pkg: shared types and constants for the single-precision multiplier
// controller.
//   state_t : controller FSM states
//   BIAS    : IEEE-754 single exponent bias
//   QNAN    : canonical quiet NaN returned for invalid operations
//   exp_t   : 10-bit signed exponent, wide enough for expa+expb-BIAS+1
package fpm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_MUL,
      S_NORM,
      S_DONE
   } state_t;

   localparam int          BIAS = 127;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef logic signed [9:0] exp_t;

endpackage

// File: rtl/fpm_mul_iter.sv
// fpm_mul_iter: iterative shift-add 24x24 mantissa multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : clear the product and load the multiplier mb
//   step       : retire the next BPC multiplier bits (MSB first)
//   ma, mb     : 24-bit mantissas (hidden 1 included); ma must stay stable
//   prod       : 48-bit product, complete after 24/BPC steps
module fpm_mul_iter
   import fpm_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        step,
   input  logic [23:0] ma,
   input  logic [23:0] mb,
   output logic [47:0] prod
);

   localparam int unsigned NB = BPC;

   logic [47:0]    prod_q, prod_d;
   logic [23:0]    mb_q, mb_d;
   logic [BPC-1:0] chunk;
   logic [47:0]    partial;

   // Multiplier bits are consumed MSB first, so the accumulator is shifted
   // up by BPC before each new partial product is added.
   always_comb begin
      prod_d  = prod_q;
      mb_d    = mb_q;
      chunk   = mb_q[23 -: BPC];
      partial = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (chunk[i]) begin
            partial = partial + ({24'd0, ma} << i);
         end
      end
      if (start) begin
         prod_d = '0;
         mb_d   = mb;
      end else if (step) begin
         prod_d = (prod_q << BPC) + partial;
         mb_d   = mb_q << BPC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         mb_q   <= '0;
      end else begin
         prod_q <= prod_d;
         mb_q   <= mb_d;
      end
   end

   assign prod = prod_q;

endmodule

// File: rtl/fpm_ctrl.sv
// fpm_ctrl: IEEE-754 single-precision multiplier sequencer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, opa/opb captured on accept
//   out_valid/out_ready  : product handshake, result/flags held until taken
//   nan, inf, zer        : result class flags (at most one set)
//   busy                 : high whenever the FSM is not IDLE
// Parameter BPC: mantissa product bits retired per MUL cycle (1,2,3,4,6,8).
module fpm_ctrl
   import fpm_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        nan,
   output logic        inf,
   output logic        zer,
   output logic        busy
);

   localparam int unsigned STEPS = 24 / BPC;

   state_t      state_q, state_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic [31:0] result_q, result_d;
   logic        nan_q, nan_d, inf_q, inf_d, zer_q, zer_d;
   logic [4:0]  cnt_q, cnt_d;
   exp_t        e_q, e_d, e_n;
   logic        start, step;
   logic [47:0] prod;
   logic [22:0] frac;
   logic        s, za, zb, ia, ib, na, nb;
   logic        prod_unused;

   always_comb begin
      s  = opa_q[31] ^ opb_q[31];
      za = (opa_q[30:23] == 8'h00);
      zb = (opb_q[30:23] == 8'h00);
      ia = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'd0);
      ib = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'd0);
      na = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'd0);
      nb = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'd0);
      prod_unused = ^prod[22:0];
   end

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      nan_d    = nan_q;
      inf_d    = inf_q;
      zer_d    = zer_q;
      cnt_d    = cnt_q;
      e_d      = e_q;
      e_n      = e_q;
      frac     = '0;
      start    = 1'b0;
      step     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               opa_d   = opa;
               opb_d   = opb;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            nan_d = 1'b0;
            inf_d = 1'b0;
            zer_d = 1'b0;
            if (na || nb || (ia && zb) || (ib && za)) begin
               nan_d    = 1'b1;
               result_d = QNAN;
               state_d  = S_DONE;
            end else if (ia || ib) begin
               inf_d    = 1'b1;
               result_d = {s, 8'hFF, 23'h0};
               state_d  = S_DONE;
            end else if (za || zb) begin
               zer_d    = 1'b1;
               result_d = {s, 31'h0};
               state_d  = S_DONE;
            end else begin
               e_d     = exp_t'({2'b00, opa_q[30:23]}) + exp_t'({2'b00, opb_q[30:23]})
                         - exp_t'(BIAS);
               cnt_d   = '0;
               start   = 1'b1;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            step  = 1'b1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(STEPS - 1)) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            // Product of two [1,2) mantissas lies in [1,4); bit 47 marks [2,4).
            e_n  = e_q + exp_t'({9'd0, prod[47]});
            frac = prod[47] ? prod[46:24] : prod[45:23];
            if (e_n >= exp_t'(255)) begin
               inf_d    = 1'b1;
               result_d = {s, 8'hFF, 23'h0};
            end else if (e_n <= exp_t'(0)) begin
               zer_d    = 1'b1;
               result_d = {s, 31'h0};
            end else begin
               result_d = {s, e_n[7:0], frac};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         zer_q    <= 1'b0;
         cnt_q    <= '0;
         e_q      <= '0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
         zer_q    <= zer_d;
         cnt_q    <= cnt_d;
         e_q      <= e_d;
      end
   end

   fpm_mul_iter #(.BPC(BPC)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .step  (step),
      .ma    ({1'b1, opa_q[22:0]}),
      .mb    ({1'b1, opb_q[22:0]}),
      .prod  (prod)
   );

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign nan       = nan_q;
   assign inf       = inf_q;
   assign zer       = zer_q;

endmodule

// File: tb/tb_fpm_ctrl.sv
// tb_fpm_ctrl: scoreboard bench for fpm_ctrl. Two instances (BPC=1 and
// BPC=4) share the clock; each has its own expected-response queue fed by
// the stimulus tasks and drained by an independent monitor.
module tb_fpm_ctrl;

   typedef struct packed {
      logic [31:0] res;
      logic        n;
      logic        i;
      logic        z;
      logic [7:0]  lat;
      logic [31:0] acc;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] opa       [2];
   logic [31:0] opb       [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] result    [2];
   logic        nan_o     [2];
   logic        inf_o     [2];
   logic        zer_o     [2];
   logic        busy      [2];

   rec_t sbq [2][$];
   int   rdy_mode [2];
   int   last_acc [2];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      fpm_ctrl #(.BPC(k == 0 ? 1 : 4)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .opa       (opa[k]),
         .opb       (opb[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .result    (result[k]),
         .nan       (nan_o[k]),
         .inf       (inf_o[k]),
         .zer       (zer_o[k]),
         .busy      (busy[k])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic int bpc_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   // Reference: classify, then exact integer product and normalise/truncate.
   function automatic rec_t ref_mul(input logic [31:0] a, input logic [31:0] b, input int bpc);
      rec_t        r;
      int          ea, eb, e;
      logic        s, za, zb, ia, ib, na, nb;
      logic [47:0] p;
      logic [22:0] f;
      r   = '0;
      s   = a[31] ^ b[31];
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      za  = (ea == 0);
      zb  = (eb == 0);
      ia  = (ea == 255) && (a[22:0] == 0);
      ib  = (eb == 255) && (b[22:0] == 0);
      na  = (ea == 255) && (a[22:0] != 0);
      nb  = (eb == 255) && (b[22:0] != 0);
      r.lat = 8'd2;
      if (na || nb || (ia && zb) || (ib && za)) begin
         r.res = 32'h7FC0_0000; r.n = 1'b1;
      end else if (ia || ib) begin
         r.res = {s, 8'hFF, 23'h0}; r.i = 1'b1;
      end else if (za || zb) begin
         r.res = {s, 31'h0}; r.z = 1'b1;
      end else begin
         r.lat = 8'(3 + 24 / bpc);
         p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
         e = ea + eb - 127;
         if (p[47]) begin
            e = e + 1;
            f = p[46:24];
         end else begin
            f = p[45:23];
         end
         if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.i = 1'b1;
         end else if (e <= 0) begin
            r.res = {s, 31'h0}; r.z = 1'b1;
         end else begin
            r.res = {s, 8'(e), f};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      int unsigned sel;
      logic [7:0]  ex;
      logic [22:0] fr;
      sel = $urandom_range(0, 9);
      fr  = 23'($urandom);
      case (sel)
         0:       ex = 8'h00;
         1:       begin ex = 8'hFF; if ($urandom_range(0, 1) == 0) fr = '0; end
         2:       ex = 8'($urandom_range(1, 40));
         3:       ex = 8'($urandom_range(200, 254));
         default: ex = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom), ex, fr};
   endfunction

   // Precondition: called just after a rising edge; returns just after the
   // accept edge.
   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
      rec_t r;
      int   n;
      n = 0;
      in_valid[k] = 1'b1;
      opa[k] = a;
      opb[k] = b;
      @(negedge clk);
      while (!in_ready[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[k]) begin
         checks++; errors++;
         $display("FAIL accept_timeout[%0d]: in_ready stuck at 0, expected 1", k);
      end else begin
         r = ref_mul(a, b, bpc_of(k));
         r.acc = 32'(cyc + 1);
         last_acc[k] = cyc + 1;
         sbq[k].push_back(r);
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      opa[k] = $urandom;
      opb[k] = $urandom;
   endtask

   task automatic drain(input int k);
      int n;
      n = 0;
      while (sbq[k].size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq[k].size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout[%0d]: %0d results outstanding, expected 0", k, sbq[k].size());
         sbq[k].delete();
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_side
      logic prev_ov = 1'b0;
      rec_t r;

      always @(posedge clk) begin
         #1;
         if (rdy_mode[k] == 1)      out_ready[k] = 1'($urandom_range(0, 1));
         else if (rdy_mode[k] == 2) out_ready[k] = 1'b0;
         else                       out_ready[k] = 1'b1;
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            prev_ov = 1'b0;
         end else if (out_valid[k]) begin
            if (sbq[k].size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out_valid[%0d]: out_valid=1 with no op pending, expected 0", k);
            end else begin
               r = sbq[k][0];
               if (!prev_ov) chk("latency", 32'(cyc - int'(r.acc) + 1), 32'(r.lat));
               chk("result", result[k], r.res);
               chk("flags", {29'd0, nan_o[k], inf_o[k], zer_o[k]}, {29'd0, r.n, r.i, r.z});
               if (out_ready[k]) begin
                  void'(sbq[k].pop_front());
                  prev_ov = 1'b0;
               end else begin
                  prev_ov = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         opa[k] = '0;
         opb[k] = '0;
         rdy_mode[k] = 0;
         out_ready[k] = 1'b1;
         last_acc[k] = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_out_valid", {31'd0, out_valid[k]}, 32'd0);
         chk("rst_result", result[k], 32'd0);
         chk("rst_flags", {29'd0, nan_o[k], inf_o[k], zer_o[k]}, 32'd0);
         chk("rst_busy", {31'd0, busy[k]}, 32'd0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", {31'd0, in_ready[0]}, 32'd1);

      // Directed cases on the BPC=1 instance.
      issue(0, 32'h4000_0000, 32'h4040_0000); drain(0);
      issue(0, 32'h7F80_0000, 32'h0000_0000); drain(0);
      issue(0, 32'h7F00_0000, 32'h7F00_0000); drain(0);
      issue(0, 32'h0080_0000, 32'h0080_0000); drain(0);
      issue(0, 32'hC000_0000, 32'h4000_0000); drain(0);
      issue(0, 32'h3F80_0000, 32'h3F80_0000); drain(0);

      // Randomised traffic with random backpressure.
      rdy_mode[0] = 1;
      rdy_mode[1] = 1;
      for (int i = 0; i < 40; i++) issue(0, rnd_op(), rnd_op());
      drain(0);
      for (int i = 0; i < 30; i++) issue(1, rnd_op(), rnd_op());
      drain(1);

      // Held backpressure: DONE must hold and ignore new requests.
      rdy_mode[0] = 2;
      @(posedge clk); #1;
      issue(0, 32'h3FC0_0000, 32'h3FC0_0000);
      n = 0;
      while (!out_valid[0] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_reached_done", {31'd0, out_valid[0]}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid[0] = 1'($urandom_range(0, 1));
         opa[0] = $urandom;
         opb[0] = $urandom;
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
         chk("bp_busy", {31'd0, busy[0]}, 32'd1);
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      rdy_mode[0] = 0;
      drain(0);

      // Reset in the middle of MUL.
      issue(0, 32'h4000_0000, 32'h4040_0000);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_busy", {31'd0, busy[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", {31'd0, out_valid[0]}, 32'd0);
      chk("mr_busy", {31'd0, busy[0]}, 32'd0);
      chk("mr_result", result[0], 32'd0);
      chk("mr_flags", {29'd0, nan_o[0], inf_o[0], zer_o[0]}, 32'd0);
      sbq[0].delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mr_in_ready", {31'd0, in_ready[0]}, 32'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("mr_no_stale", {31'd0, out_valid[0]}, 32'd0);

      // Back-to-back on BPC=4: accepts spaced latency+1 = 10 cycles apart.
      rdy_mode[1] = 0;
      @(posedge clk); #1;
      issue(1, 32'h3FC0_0000, 32'h3FC0_0000);
      n = last_acc[1];
      issue(1, 32'h3FC0_0000, 32'h3FC0_0000);
      chk("b2b_spacing", 32'(last_acc[1] - n), 32'd10);
      drain(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpm_ctrl.md
FPM_CTRL -- requirements
Module: fpm_ctrl

Interface
REQ-001 SHALL have parameter BPC, default 1, giving mantissa product bits retired per MUL cycle; legal values are 1, 2, 3, 4, 6, 8.
REQ-002 SHALL have ports clk (input, 1): single clock, all state on rising edge.
REQ-003 SHALL have ports rst_n (input, 1): reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), opa (input, 32), opb (input, 32): IEEE-754 single operand handshake.
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1), result (output, 32): product handshake.
REQ-006 SHALL have ports nan, inf, zer (output, 1 each): result class flags, valid with out_valid.
REQ-007 SHALL have port busy (output, 1): high in any state other than IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, CHECK, MUL, NORM, DONE.
REQ-009 in_ready SHALL equal (state==IDLE); an operand is accepted on in_valid&in_ready, registered, and the state goes to CHECK.
REQ-010 CHECK SHALL classify the operands: exp==0 is zero (denormals flushed); exp==FF with frac==0 is inf; exp==FF with frac!=0 is NaN; inf times zero is NaN.
REQ-011 On a special case, CHECK SHALL go directly to DONE; otherwise it goes to MUL with counter=0 and exponent sum e = expa+expb-127, held in 10-bit signed form.
REQ-012 MUL SHALL shift-add BPC bits of the 24x24 mantissa product (hidden 1 included) per cycle for 24/BPC cycles, then go to NORM.
REQ-013 NORM: if p[47]=1, frac=p[46:24] and e+1; else frac=p[45:23]; rounding is truncation (toward zero).
REQ-014 Overflow is final e>=255; underflow is final e<=0.
REQ-015 Flag priority SHALL be nan > inf > zer; at most one flag is set.
REQ-016 result SHALL be 32'h7FC00000 for nan; {s,8'hFF,23'h0} for inf/overflow; {s,31'h0} for zero/underflow; otherwise {s,e[7:0],frac}, where s = sign_a ^ sign_b.
REQ-017 DONE SHALL assert out_valid; result and flags are held stable until out_ready; on out_valid&out_ready the state returns to IDLE.
REQ-018 Latency from the accept edge SHALL be: special case, out_valid at cycle 2; normal case, out_valid at cycle 3+24/BPC (27 for BPC=1).
REQ-019 There is no accept in the same cycle as a DONE handshake; throughput is one op per (latency+1) cycles minimum.
REQ-020 in_valid SHALL be ignored while busy; operands change freely with no effect.

Reset
REQ-021 rst_n low SHALL force, asynchronously: state=IDLE, out_valid=0, result=0, nan=inf=zer=0, busy=0, counter=0, product=0.
REQ-022 Reset asserted mid-operation SHALL discard the operation; no out_valid follows the release.
REQ-023 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-024 Package fpm_pkg SHALL hold the state enum, BIAS=127, QNAN=32'h7FC00000 and the 10-bit exponent typedef.
REQ-025 The shift-add mantissa datapath SHALL be sub-module fpm_mul_iter (start, BPC-step, 48-bit product out); sequencing stays in fpm_ctrl.
REQ-026 Total RTL SHALL be 120-400 lines.

Verification
REQ-027 Basic multiply: 0x40000000 * 0x40400000 (BPC=1) -> result 0x40C00000, flags 0, out_valid exactly 27 cycles after accept.
REQ-028 Invalid operation: 0x7F800000 * 0x00000000 -> result 0x7FC00000, nan=1, inf=0, zer=0, out_valid at cycle 2.
REQ-029 Overflow and underflow: 0x7F000000 * 0x7F000000 -> 0x7F800000 with inf=1; 0x00800000 * 0x00800000 -> 0x00000000 with zer=1; sign check 0xC0000000 * 0x40000000 -> 0xC0800000.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0, in_valid pulses ignored; the op completes on out_ready=1.
REQ-031 Reset mid-operation: drop rst_n at cycle 10 of MUL -> outputs reset immediately; after release, in_ready=1 and no stale out_valid.
REQ-032 Throughput: BPC=4 with back-to-back ops -> latency 9 and correct results for 1.5*1.5 = 0x40100000.
